// File: rtl/upsp_pkg.sv
// Shared defaults, frame-control state type and a counter-width helper for the upsp write buffer.
package upsp_pkg;

    localparam int UPSP_WRTDATA_WIDTH_DEF = 24;
    localparam int DST_IMG_WIDTH_DEF      = 3840;
    localparam int DST_IMG_HEIGHT_DEF     = 2160;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } upsp_state_t;

    // Counters for a dimension of 1 still need one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ac_upsp_wrbuf_if.sv
// Pixel write bus from upsp plus the AXI-stream output bus.
// The master modport is the buffer's view; the slave modport is the surrounding logic's view.
interface ac_upsp_wrbuf_if #(
    parameter int WIDTH = 24
) ();
    logic             upsp_ac_wvalid;
    logic [WIDTH-1:0] upsp_ac_wdata;
    logic             ac_upsp_wready;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tuser;
    logic             m_axis_tlast;

    modport master (
        input  upsp_ac_wvalid, upsp_ac_wdata, m_axis_tready,
        output ac_upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );

    modport slave (
        output upsp_ac_wvalid, upsp_ac_wdata, m_axis_tready,
        input  ac_upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );
endinterface

// File: rtl/upsp_sync_fifo.sv
// Synchronous first-word-fall-through FIFO: a word pushed in cycle N is readable in cycle N+1.
// Pushes while full and pops while empty are dropped; the caller gates them with full/empty.
module upsp_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != DEPTH_C);
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the read side is qualified by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);

endmodule

// File: rtl/ac_upsp_wrbuf.sv
// Buffers one frame of upsp pixels into an AXI-stream with tuser at frame start and tlast at line end.
// One cycle input-to-output latency; wready depends only on registers and drops when full or the frame is fully accepted.
module ac_upsp_wrbuf
    import upsp_pkg::*;
#(
    parameter int UPSP_WRTDATA_WIDTH = UPSP_WRTDATA_WIDTH_DEF,
    parameter int DST_IMG_WIDTH      = DST_IMG_WIDTH_DEF,
    parameter int DST_IMG_HEIGHT     = DST_IMG_HEIGHT_DEF,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    ac_upsp_wrbuf_if.master bus,
    output logic            frame_done
);
    localparam int CW   = cnt_bits(DST_IMG_WIDTH);
    localparam int RW   = cnt_bits(DST_IMG_HEIGHT);
    localparam int NPIX = DST_IMG_WIDTH * DST_IMG_HEIGHT;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int FCW  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(DST_IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(DST_IMG_HEIGHT - 1);
    localparam logic [PW-1:0] PIX_TOTAL = PW'(NPIX);

    upsp_state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] push_cnt_q, push_cnt_d;

    logic                          wready, tvalid, push, pop;
    logic [UPSP_WRTDATA_WIDTH-1:0] fifo_dat;
    logic [FCW-1:0]                fifo_cnt;
    logic                          fifo_full, fifo_empty;

    upsp_sync_fifo #(
        .WIDTH (UPSP_WRTDATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (bus.upsp_ac_wdata),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .count    (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        // The push counter stops acceptance at W*H so a fast upstream cannot spill into the next frame.
        wready     = (state_q == ST_RUN) && !fifo_full && (push_cnt_q != PIX_TOTAL);
        tvalid     = (fifo_cnt != '0);
        push       = bus.upsp_ac_wvalid && wready;
        pop        = tvalid && bus.m_axis_tready;
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        push_cnt_d = push_cnt_q;

        case (state_q)
            ST_IDLE: begin
                push_cnt_d = '0;
                if (frame_start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (push) push_cnt_d = push_cnt_q + 1'b1;
                if (pop && (col_q == COL_LAST) && (row_q == ROW_LAST)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            push_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            push_cnt_q <= push_cnt_d;
        end
    end

    // Sideband and data are qualified by tvalid so an empty buffer presents all-zero outputs.
    assign bus.ac_upsp_wready = wready;
    assign bus.m_axis_tvalid  = tvalid;
    assign bus.m_axis_tdata   = fifo_empty ? '0 : fifo_dat;
    assign bus.m_axis_tuser   = tvalid && (col_q == '0) && (row_q == '0);
    assign bus.m_axis_tlast   = tvalid && (col_q == COL_LAST);
    assign frame_done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_ac_upsp_wrbuf.sv
// Self-checking bench for ac_upsp_wrbuf with a 4x2 frame and a 4-entry buffer.
module tb_ac_upsp_wrbuf;
    localparam int DW    = 24;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 4;
    localparam int NPIX  = W * H;

    logic clk = 1'b0;
    logic rst;
    logic frame_start;
    logic frame_done;

    ac_upsp_wrbuf_if #(.WIDTH(DW)) bus ();

    ac_upsp_wrbuf #(
        .UPSP_WRTDATA_WIDTH (DW),
        .DST_IMG_WIDTH      (W),
        .DST_IMG_HEIGHT     (H),
        .FIFO_DEPTH         (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bus         (bus),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          fs;
        logic          wv;
        logic [DW-1:0] wd;
        logic          tr;
        logic          wr;
        logic          tv;
        logic [DW-1:0] td;
        logic          tu;
        logic          tl;
        logic          fd;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] in_b, input logic [7:0] wd,
                                input logic [4:0] out_b, input logic [7:0] td);
        vec_t v;
        {v.fs, v.wv, v.tr}             = in_b;
        v.wd                           = DW'(wd);
        {v.wr, v.tv, v.tu, v.tl, v.fd} = out_b;
        v.td                           = DW'(td);
        return v;
    endfunction

    // Reference model: frame phase (0 idle, 1 running, 2 done), a queue of accepted pixels and per-frame counts.
    int            phase = 0;
    logic [DW-1:0] q[$];
    int            pushed = 0;
    int            popped = 0;
    int            tuser_cnt = 0;
    int            tlast_cnt = 0;
    logic          last_in_hs = 1'b0;

    task automatic cyc();
        logic          in_hs, out_hs, hold, h_usr, h_lst;
        logic [DW-1:0] in_dat, h_dat;
        chk("wready", 32'(bus.ac_upsp_wready), 32'(phase == 1 && q.size() < DEPTH && pushed < NPIX));
        chk("tvalid", 32'(bus.m_axis_tvalid), 32'(q.size() != 0));
        chk("frame_done", 32'(frame_done), 32'(phase == 2));
        if (bus.m_axis_tvalid && q.size() != 0) begin
            chk("tdata", 32'(bus.m_axis_tdata), 32'(q[0]));
            chk("tuser", 32'(bus.m_axis_tuser), 32'(popped == 0));
            chk("tlast", 32'(bus.m_axis_tlast), 32'((popped % W) == W - 1));
        end
        in_hs  = bus.upsp_ac_wvalid && bus.ac_upsp_wready;
        in_dat = bus.upsp_ac_wdata;
        out_hs = bus.m_axis_tvalid && bus.m_axis_tready;
        if (out_hs && bus.m_axis_tuser) tuser_cnt++;
        if (out_hs && bus.m_axis_tlast) tlast_cnt++;
        hold  = bus.m_axis_tvalid && !bus.m_axis_tready && !rst;
        h_dat = bus.m_axis_tdata;
        h_usr = bus.m_axis_tuser;
        h_lst = bus.m_axis_tlast;
        @(posedge clk);
        #1;
        last_in_hs = in_hs;
        if (rst) begin
            q.delete();
            pushed = 0;
            popped = 0;
            phase  = 0;
        end else begin
            if (in_hs) begin
                q.push_back(in_dat);
                pushed++;
            end
            if (out_hs && q.size() != 0) begin
                void'(q.pop_front());
                popped++;
            end
            if (phase == 2) phase = 0;
            else if (phase == 0 && frame_start) begin
                phase  = 1;
                pushed = 0;
                popped = 0;
            end else if (phase == 1 && popped == NPIX) phase = 2;
        end
        if (hold) begin
            chk("hold_tvalid", 32'(bus.m_axis_tvalid), 32'(1'b1));
            chk("hold_tdata", 32'(bus.m_axis_tdata), 32'(h_dat));
            chk("hold_tuser", 32'(bus.m_axis_tuser), 32'(h_usr));
            chk("hold_tlast", 32'(bus.m_axis_tlast), 32'(h_lst));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wready"}, 32'(bus.ac_upsp_wready), 32'(1'b0));
        chk({tag, "_tvalid"}, 32'(bus.m_axis_tvalid), 32'(1'b0));
        chk({tag, "_tdata"}, 32'(bus.m_axis_tdata), 32'(0));
        chk({tag, "_tuser"}, 32'(bus.m_axis_tuser), 32'(1'b0));
        chk({tag, "_tlast"}, 32'(bus.m_axis_tlast), 32'(1'b0));
        chk({tag, "_frame_done"}, 32'(frame_done), 32'(1'b0));
    endtask

    // Runs until the model returns to idle, feeding pixels base, base+1, ... with tready held at 1.
    task automatic drain_frame(input string tag, input int base);
        int n = 0;
        int k = pushed;
        bus.m_axis_tready = 1'b1;
        bus.upsp_ac_wvalid = 1'b1;
        bus.upsp_ac_wdata  = DW'(base + k);
        while (phase != 0 && n < 200) begin
            cyc();
            n++;
            if (last_in_hs) begin
                k++;
                bus.upsp_ac_wdata = DW'(base + k);
            end
        end
        if (n >= 200) chk({tag, "_timeout"}, 32'(phase), 32'(0));
        bus.upsp_ac_wvalid = 1'b0;
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = mk(3'b101, 8'h00, 5'b10000, 8'h00);
        tbl[1]  = mk(3'b011, 8'h01, 5'b11100, 8'h01);
        tbl[2]  = mk(3'b011, 8'h02, 5'b11000, 8'h02);
        tbl[3]  = mk(3'b011, 8'h03, 5'b11000, 8'h03);
        tbl[4]  = mk(3'b011, 8'h04, 5'b11010, 8'h04);
        tbl[5]  = mk(3'b011, 8'h05, 5'b11000, 8'h05);
        tbl[6]  = mk(3'b011, 8'h06, 5'b11000, 8'h06);
        tbl[7]  = mk(3'b011, 8'h07, 5'b11000, 8'h07);
        tbl[8]  = mk(3'b011, 8'h08, 5'b01010, 8'h08);
        tbl[9]  = mk(3'b011, 8'h09, 5'b00001, 8'h00);
        tbl[10] = mk(3'b011, 8'h09, 5'b00000, 8'h00);
        tbl[11] = mk(3'b011, 8'h09, 5'b00000, 8'h00);
        tbl[12] = mk(3'b011, 8'h09, 5'b00000, 8'h00);

        rst = 1'b1;
        frame_start = 1'b0;
        bus.upsp_ac_wvalid = 1'b0;
        bus.upsp_ac_wdata  = '0;
        bus.m_axis_tready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Single 4x2 frame with continuous traffic, then idle cycles with wvalid high.
        foreach (tbl[i]) begin
            frame_start        = tbl[i].fs;
            bus.upsp_ac_wvalid = tbl[i].wv;
            bus.upsp_ac_wdata  = tbl[i].wd;
            bus.m_axis_tready  = tbl[i].tr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_wready", i), 32'(bus.ac_upsp_wready), 32'(tbl[i].wr));
            chk($sformatf("vec%0d_tvalid", i), 32'(bus.m_axis_tvalid), 32'(tbl[i].tv));
            chk($sformatf("vec%0d_tdata", i), 32'(bus.m_axis_tdata), 32'(tbl[i].td));
            chk($sformatf("vec%0d_tuser", i), 32'(bus.m_axis_tuser), 32'(tbl[i].tu));
            chk($sformatf("vec%0d_tlast", i), 32'(bus.m_axis_tlast), 32'(tbl[i].tl));
            chk($sformatf("vec%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].fd));
        end
        frame_start = 1'b0;
        bus.upsp_ac_wvalid = 1'b0;

        // Output stalled for 10 cycles: only DEPTH pixels may enter and the head must stay put.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        begin
            int k = 0;
            bus.m_axis_tready  = 1'b0;
            bus.upsp_ac_wvalid = 1'b1;
            bus.upsp_ac_wdata  = DW'(32'h10);
            repeat (10) begin
                cyc();
                if (last_in_hs) begin
                    k++;
                    bus.upsp_ac_wdata = DW'(32'h10 + k);
                end
            end
        end
        chk("stall_accepts", 32'(pushed), 32'(DEPTH));
        chk("stall_wready", 32'(bus.ac_upsp_wready), 32'(1'b0));
        chk("stall_head", 32'(bus.m_axis_tdata), 32'(32'h10));
        drain_frame("stall", 32'h10);

        // Reset after five accepted pixels, then a fresh frame.
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        begin
            int n = 0;
            int k = 0;
            bus.m_axis_tready  = 1'b1;
            bus.upsp_ac_wvalid = 1'b1;
            bus.upsp_ac_wdata  = DW'(32'h20);
            while (pushed < 5 && n < 50) begin
                cyc();
                n++;
                if (last_in_hs) begin
                    k++;
                    bus.upsp_ac_wdata = DW'(32'h20 + k);
                end
            end
            if (n >= 50) chk("rst_fill_timeout", 32'(pushed), 32'(5));
        end
        bus.upsp_ac_wvalid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_all_zero("midrst");
        repeat (3) cyc();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        tuser_cnt = 0;
        tlast_cnt = 0;
        drain_frame("after_rst", 32'h40);
        chk("after_rst_tuser_cnt", 32'(tuser_cnt), 32'(1));
        chk("after_rst_tlast_cnt", 32'(tlast_cnt), 32'(H));

        // Three frames with random valid/ready and random data.
        tuser_cnt = 0;
        tlast_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            int n = 0;
            frame_start = 1'b1;
            bus.upsp_ac_wvalid = 1'b0;
            cyc();
            frame_start = 1'b0;
            while (phase != 0 && n < 2000) begin
                if (last_in_hs || !bus.upsp_ac_wvalid) begin
                    bus.upsp_ac_wvalid = 1'($urandom_range(0, 1));
                    bus.upsp_ac_wdata  = DW'($urandom);
                end
                bus.m_axis_tready = 1'($urandom_range(0, 1));
                // A frame_start while running must be ignored.
                frame_start = ($urandom_range(0, 15) == 0);
                cyc();
                n++;
            end
            frame_start = 1'b0;
            if (n >= 2000) chk("random_timeout", 32'(phase), 32'(0));
        end
        bus.upsp_ac_wvalid = 1'b0;
        chk("random_tuser_cnt", 32'(tuser_cnt), 32'(3));
        chk("random_tlast_cnt", 32'(tlast_cnt), 32'(3 * H));
        chk("random_left_over", 32'(q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
